// File: rtl/scan_mux_nx1_pkg.sv
// Shared constants and helpers for the scan_mux_nx1 N:1 sampling multiplexer.
package scan_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Bit offset of channel k inside the flattened in_data bus.
  function automatic int unsigned ch_offset(input int unsigned k, input int unsigned data_w);
    return k * data_w;
  endfunction

endpackage

// File: rtl/scan_mux_nx1_if.sv
// Output stream of scan_mux_nx1: valid/ready handshake plus sample metadata.
// master = the mux (producer), slave = the serial consumer.
interface scan_mux_nx1_if #(
  parameter int N_CH   = 16,
  parameter int DATA_W = 1
) ();
  localparam int SEL_W = $clog2(N_CH);

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [SEL_W-1:0]  out_ch;
  logic              out_last;
  logic              out_err;

  modport master (
    output out_valid, out_data, out_ch, out_last, out_err,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_ch, out_last, out_err,
    output out_ready
  );
endinterface

// File: rtl/scan_mux_nx1_next_ch.sv
// Cyclic priority search over a channel enable mask, used by the skip-scan
// build of scan_mux_nx1. Only compiled when SCAN_MUX_SKIP_EN is defined.
//   cur_idx  : first enabled channel at or above idx (cyclic)
//   next_idx : first enabled channel strictly above cur_idx (cyclic)
//   lo_idx / hi_idx : lowest / highest enabled channel (0 when none)
//   any_en   : at least one channel enabled
`ifdef SCAN_MUX_SKIP_EN
module scan_mux_next_ch #(
  parameter  int N_CH  = 16,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  mask,
  input  logic [SEL_W-1:0] idx,
  output logic [SEL_W-1:0] cur_idx,
  output logic [SEL_W-1:0] next_idx,
  output logic [SEL_W-1:0] lo_idx,
  output logic [SEL_W-1:0] hi_idx,
  output logic             any_en
);

  logic cur_hit;
  logic next_hit;

  assign any_en = |mask;

  // Descending scans leave the lowest qualifying index as the final assignment.
  always_comb begin
    lo_idx   = '0;
    hi_idx   = '0;
    cur_idx  = '0;
    next_idx = '0;
    cur_hit  = 1'b0;
    next_hit = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (mask[k]) begin
        lo_idx = SEL_W'(k);
        if (k >= int'(idx)) begin
          cur_idx = SEL_W'(k);
          cur_hit = 1'b1;
        end
      end
    end
    if (!cur_hit) cur_idx = lo_idx;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (mask[k] && (k > int'(cur_idx))) begin
        next_idx = SEL_W'(k);
        next_hit = 1'b1;
      end
    end
    if (!next_hit) next_idx = lo_idx;
    for (int k = 0; k < N_CH; k++) begin
      if (mask[k]) hi_idx = SEL_W'(k);
    end
  end

endmodule
`endif

// File: rtl/scan_mux_nx1.sv
// scan_mux_nx1: N:1 word multiplexer with a registered valid/ready output.
// Manual mode picks the channel from sel; scan mode walks an internal pointer
// round-robin, advancing once per captured sample.
// Optional build macro SCAN_MUX_SKIP_EN adds ch_mask so the scan visits only
// enabled channels.
module scan_mux_nx1
  import scan_mux_pkg::*;
#(
  parameter  int N_CH   = 16,
  parameter  int DATA_W = 1,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   en,
`ifdef SCAN_MUX_SKIP_EN
  input  logic [N_CH-1:0]        ch_mask,
`endif
  scan_mux_nx1_if.master         out_if
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  logic [DATA_W-1:0] ch_words [N_CH];
  logic [SEL_W-1:0]  ptr_reg;
  logic [SEL_W-1:0]  scan_ch;
  logic [SEL_W-1:0]  ptr_adv;
  logic [SEL_W-1:0]  ptr_home;
  logic              scan_ok;
  logic              scan_last;
  logic              free;
  logic              capture;
  logic [DATA_W-1:0] data_next;
  logic [SEL_W-1:0]  ch_next;
  logic              last_next;
  logic              err_next;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_slice
    assign ch_words[gi] = in_data[ch_offset(gi, DATA_W) +: DATA_W];
  end

`ifdef SCAN_MUX_SKIP_EN
  logic [SEL_W-1:0] hi_idx;
  logic             any_en;

  // ptr may point at a channel masked off since it was loaded; the search
  // resolves it to the next enabled one so no stale channel is sampled.
  scan_mux_next_ch #(.N_CH(N_CH)) u_next_ch (
    .mask     (ch_mask),
    .idx      (ptr_reg),
    .cur_idx  (scan_ch),
    .next_idx (ptr_adv),
    .lo_idx   (ptr_home),
    .hi_idx   (hi_idx),
    .any_en   (any_en)
  );

  assign scan_ok   = any_en;
  assign scan_last = (scan_ch == hi_idx);
`else
  assign scan_ch   = ptr_reg;
  assign ptr_adv   = (ptr_reg == LAST_CH) ? '0 : ptr_reg + 1'b1;
  assign ptr_home  = '0;
  assign scan_ok   = 1'b1;
  assign scan_last = (ptr_reg == LAST_CH);
`endif

  assign free    = !out_if.out_valid || out_if.out_ready;
  assign capture = en && free && ((mode == MODE_MANUAL) || scan_ok);

  // Select the sample and its metadata for the current mode.
  always_comb begin
    data_next = '0;
    ch_next   = '0;
    last_next = 1'b0;
    err_next  = 1'b0;
    if (mode == MODE_MANUAL) begin
      ch_next  = sel;
      err_next = (int'(sel) >= N_CH);
      if (!err_next) data_next = ch_words[sel];
    end else begin
      ch_next   = scan_ch;
      data_next = ch_words[scan_ch];
      last_next = scan_last;
    end
  end

  // Output register: load on capture, retire on accept, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_if.out_valid <= 1'b0;
      out_if.out_data  <= '0;
      out_if.out_ch    <= '0;
      out_if.out_last  <= 1'b0;
      out_if.out_err   <= 1'b0;
    end else if (capture) begin
      out_if.out_valid <= 1'b1;
      out_if.out_data  <= data_next;
      out_if.out_ch    <= ch_next;
      out_if.out_last  <= last_next;
      out_if.out_err   <= err_next;
    end else if (out_if.out_ready) begin
      out_if.out_valid <= 1'b0;
    end
  end

  // Scan pointer: parked at home in manual mode, advances once per scan capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= ptr_home;
    end else if (mode == MODE_MANUAL) begin
      ptr_reg <= ptr_home;
    end else if (capture) begin
      ptr_reg <= ptr_adv;
    end
  end

endmodule

// File: doc/scan_mux_nx1.md
Name: scan_mux_nx1

Overview:
- Parametrised N:1 word multiplexer with a registered output and a valid/ready output handshake.
- Supports two modes:
  - Manual: channel chosen by the `sel` input.
  - Scan: an internal pointer walks the channels round-robin, one sample per accepted transfer.
- Sits between a bank of sampled sources (switch/sensor registers) and a single serial consumer.
- Supersedes the fixed 16x1 bit mux trees.

Parameters:
- N_CH, 16, number of input channels, 2..256; need not be a power of two.
- DATA_W, 1, bits per channel.
- SEL_W, $clog2(N_CH), select/pointer width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_data  in  N_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
- mode  in  1  0 = manual, 1 = scan
- sel  in  SEL_W  manual-mode channel select
- en  in  1  request to capture a sample
- out_valid  out  1  output register holds an unconsumed sample
- out_ready  in  1  consumer accepts the sample when out_valid & out_ready
- out_data  out  DATA_W  captured sample
- out_ch  out  SEL_W  channel index of out_data
- out_last  out  1  sample is the final channel of a scan frame
- out_err  out  1  manual select was out of range

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid, out_data, out_ch, out_last, out_err and the internal pointer ptr all go to 0.
  - rst has priority over every other input; an in-flight sample is discarded.
- Slot free: free = !out_valid | out_ready.
- Capture:
  - Capture occurs when en & free.
  - On the next edge the output registers load and out_valid=1. Latency is 1 cycle from en to out_valid.
- Idle: if not capturing and out_valid & out_ready, then out_valid goes to 0 and the other outputs hold their last value.
- Back-pressure: while out_valid & !out_ready, all out_* are held stable, en is ignored, and ptr does not move.
- Simultaneous accept and capture (out_ready=1 while en=1): the new sample replaces the old one back-to-back with no bubble, giving full throughput of 1 sample per cycle.
- Manual mode (mode=0):
  - out_ch = sel; out_data = channel sel; out_last = 0.
  - If sel >= N_CH: out_data = 0, out_err = 1; otherwise out_err = 0.
  - ptr is held at 0 throughout manual mode, so every entry into scan starts at channel 0.
- Scan mode (mode=1):
  - out_ch = ptr; out_data = channel ptr; out_err = 0.
  - out_last = (ptr == N_CH-1).
  - On each capture, ptr becomes ptr+1, wrapping from N_CH-1 to 0.
- Mode change mid-frame:
  - scan -> manual: ptr clears on the next edge.
  - The output register is unaffected; a held sample stays until accepted.
- Arithmetic: SEL_W-bit compare and increment only; no overflow beyond wrap.

Optional Feature:
- Macro: SCAN_MUX_SKIP_EN.
- Defined:
  - Adds input port ch_mask [N_CH-1:0].
  - Scan mode visits only channels with a mask bit of 1.
  - On reset or scan entry, ptr = lowest enabled index.
  - After each capture, ptr = next enabled index above ptr, searched cyclically.
  - out_last = 1 when the captured channel is the highest enabled one.
  - If ptr's own bit is cleared mid-frame, the next capture uses the next enabled channel above ptr.
  - If ch_mask is all zero, en is ignored in scan mode (no capture) and ptr holds.
  - Manual mode ignores ch_mask.
- Undefined: no ch_mask port; every channel 0..N_CH-1 is scanned.

Decomposition:
- Package scan_mux_pkg:
  - MODE_MANUAL=1'b0 and MODE_SCAN=1'b1 constants.
  - Helper function for the channel slice offset (k*DATA_W).
- One sub-module, scan_mux_next_ch:
  - Combinational cyclic priority search taking mask, current index, lowest-enabled, highest-enabled and any-enabled.
  - Instantiated only under SCAN_MUX_SKIP_EN.

Test Plan:
- Manual select and latency:
  - Stimulus: N_CH=16, DATA_W=8, channel k = 8'hA0+k, mode=0, sel=5, en=1, out_ready=1.
  - Response: one cycle later out_valid=1, out_data=8'hA5, out_ch=5, out_err=0.
- Out-of-range select:
  - Stimulus: N_CH=12, sel=13, en=1.
  - Response: out_data=0, out_err=1, out_ch=13.
- Scan full throughput:
  - Stimulus: N_CH=16, mode=1, en=1 and out_ready=1 held for 20 cycles.
  - Response: out_ch sequence 0..15 then 0..3; out_last=1 only on ch 15; out_valid continuous.
- Back-pressure:
  - Stimulus: scan mode, drop out_ready for 3 cycles while out_ch=4.
  - Response: out_data and out_ch held at ch 4; after release, the next sample is ch 5 with no skip or duplicate.
- Reset and mode change mid-frame:
  - Stimulus: rst=1 during scan at ptr=9.
  - Response: all outputs 0 next edge; next capture is ch 0. A mode 1->0->1 toggle also restarts at ch 0.
- SCAN_MUX_SKIP_EN:
  - Stimulus: ch_mask=16'h0112.
  - Response: out_ch cycles 1,4,8,1,... with out_last on 8. Setting ch_mask=0 gives no further out_valid.
